// File: rtl/dpi_call_arbiter.sv
// rtl/dpi_call_arbiter.sv - round-robin arbiter sharing one single-outstanding DPI call bridge
// Optional wait timeout enabled by defining DPI_CALL_TIMEOUT_EN.
module dpi_call_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 4,
  parameter int ARG_W   = 32,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  input  logic [NUM_REQ*ARG_W-1:0] req_arg,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [RES_W-1:0]         req_result,
  output logic                     req_err,
  output logic                     call_valid,
  input  logic                     call_ready,
  output logic [OP_W-1:0]          call_op,
  output logic [ARG_W-1:0]         call_arg,
  input  logic                     rsp_valid,
  input  logic [RES_W-1:0]         rsp_data,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   scan_idx;

`ifdef DPI_CALL_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return i + IDX_W'(1);
  endfunction

  // Scan upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    arg_d    = arg_q;
    result_d = result_q;
`ifdef DPI_CALL_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          gnt_d   = grant_idx;
          op_d    = req_op[grant_idx*OP_W +: OP_W];
          arg_d   = req_arg[grant_idx*ARG_W +: ARG_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // rsp_valid is deliberately not looked at here; the bridge answers after acceptance.
        if (call_ready) begin
          state_d = WAIT;
`ifdef DPI_CALL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          result_d = rsp_data;
          state_d  = RESP;
`ifdef DPI_CALL_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
          result_d = '1;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        rr_ptr_d = next_idx(gnt_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      arg_q    <= '0;
      result_q <= '0;
`ifdef DPI_CALL_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      result_q <= result_d;
`ifdef DPI_CALL_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    req_ready  = '0;
    req_done   = '0;
    req_result = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
    if (state_q == RESP) begin
      req_done   = NUM_REQ'(1) << gnt_q;
      req_result = result_q;
    end
  end

`ifdef DPI_CALL_TIMEOUT_EN
  assign req_err = (state_q == RESP) ? err_q : 1'b0;
`else
  assign req_err = 1'b0;
`endif

  assign call_valid = (state_q == ISSUE);
  assign call_op    = (state_q != IDLE) ? op_q  : '0;
  assign call_arg   = (state_q != IDLE) ? arg_q : '0;
  assign busy       = (state_q != IDLE);

endmodule
